// File: rtl/ram_access_seq_if.sv
// Request/response and RAM-side signals of the byte-serial RAM access sequencer.
// The "slave" modport is the sequencer's view; "master" is the core/RAM environment's view.
interface ram_access_seq_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  start;
  logic                  is_write;
  logic [1:0]            size;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [7:0]            mem_data_out;
  logic [7:0]            mem_data_in;
  logic                  mem_write_enable;

  modport master (
    output start, is_write, size, address, wdata, mem_data_in,
    input  rdata, busy, done, mem_address, mem_data_out, mem_write_enable
  );

  modport slave (
    input  start, is_write, size, address, wdata, mem_data_in,
    output rdata, busy, done, mem_address, mem_data_out, mem_write_enable
  );
endinterface

// File: rtl/ram_access_seq.sv
// Splits an 8/16/32-bit little-endian load/store into consecutive byte accesses on a byte RAM
// with one-cycle registered read data, and reassembles load bytes into a 32-bit word.
module ram_access_seq #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input logic              clk,
  input logic              reset,
  ram_access_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StReadLast} state_e;

  state_e                r_state, w_state;
  logic [1:0]            r_last, w_last;          // byte count minus one
  logic [31:0]           r_wdata, w_wdata;
  logic [2:0]            r_edge, w_edge;          // edges seen since acceptance
  logic [31:0]           r_rdata, w_rdata;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic [ADDR_WIDTH-1:0] r_mem_address, w_mem_address;
  logic [7:0]            r_mem_data_out, w_mem_data_out;
  logic                  r_mem_we, w_mem_we;

  logic [1:0]            w_next_idx;
  logic [1:0]            w_capture_idx;
  logic [2:0]            w_last_ext;

  assign w_next_idx    = r_edge[1:0] + 2'd1;
  // Read data lags the address by two edges, so the byte landing now is edge count minus one.
  assign w_capture_idx = r_edge[1:0] - 2'd1;
  assign w_last_ext    = {1'b0, r_last};

  always_comb begin
    w_state        = r_state;
    w_last         = r_last;
    w_wdata        = r_wdata;
    w_edge         = r_edge;
    w_rdata        = r_rdata;
    w_busy         = r_busy;
    w_done         = 1'b0;
    w_mem_address  = r_mem_address;
    w_mem_data_out = r_mem_data_out;
    w_mem_we       = r_mem_we;

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          unique case (bus.size)
            2'b00:   w_last = 2'd0;
            2'b01:   w_last = 2'd1;
            default: w_last = 2'd3;
          endcase
          w_wdata        = bus.wdata;
          w_edge         = 3'd0;
          w_busy         = 1'b1;
          w_mem_address  = bus.address;
          w_mem_we       = bus.is_write;
          w_mem_data_out = bus.wdata[7:0];
          if (bus.is_write) begin
            w_state = StWrite;
          end else begin
            w_rdata = 32'd0;
            w_state = (w_last == 2'd0) ? StReadLast : StRead;
          end
        end
      end

      StWrite: begin
        if (r_edge == w_last_ext) begin
          w_mem_we = 1'b0;
          w_busy   = 1'b0;
          w_done   = 1'b1;
          w_edge   = 3'd0;
          w_state  = StIdle;
        end else begin
          w_edge         = r_edge + 3'd1;
          w_mem_address  = r_mem_address + 1'b1;
          w_mem_data_out = r_wdata[{w_next_idx, 3'b000} +: 8];
        end
      end

      StRead, StReadLast: begin
        w_edge = r_edge + 3'd1;
        if (r_edge != 3'd0) begin
          w_rdata[{w_capture_idx, 3'b000} +: 8] = bus.mem_data_in;
        end
        if (r_state == StRead) begin
          w_mem_address = r_mem_address + 1'b1;
          if (r_edge + 3'd1 == w_last_ext) begin
            w_state = StReadLast;
          end
        end else if (r_edge == w_last_ext + 3'd1) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_edge  = 3'd0;
          w_state = StIdle;
        end
      end

      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_last         <= 2'd0;
      r_wdata        <= 32'd0;
      r_edge         <= 3'd0;
      r_rdata        <= 32'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_mem_address  <= '0;
      r_mem_data_out <= 8'd0;
      r_mem_we       <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_last         <= w_last;
      r_wdata        <= w_wdata;
      r_edge         <= w_edge;
      r_rdata        <= w_rdata;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_mem_address  <= w_mem_address;
      r_mem_data_out <= w_mem_data_out;
      r_mem_we       <= w_mem_we;
    end
  end

  assign bus.rdata            = r_rdata;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_data_out     = r_mem_data_out;
  assign bus.mem_write_enable = r_mem_we;

endmodule

// File: tb/tb_ram_access_seq.sv
// Bench for ram_access_seq: byte RAM model, byte-image reference of expected RAM contents,
// directed scenarios followed by randomized transactions.
module tb_ram_access_seq;
  localparam int AW  = 12;
  localparam int MEM = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_access_seq_if #(.ADDR_WIDTH(AW)) bus ();

  ram_access_seq #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bit [7:0] ram     [MEM];
  bit [7:0] ref_mem [MEM];
  int       wr_count = 0;
  int       checks   = 0;
  int       errors   = 0;

  // Byte RAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      ram[bus.mem_address] <= bus.mem_data_out;
      wr_count             <= wr_count + 1;
    end
    bus.mem_data_in <= ram[bus.mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int wrap(input int a);
    return a % MEM;
  endfunction

  function automatic logic [31:0] ref_read(input logic [AW-1:0] a, input logic [1:0] sz);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < nbytes(sz); i++) r = r | (32'(ref_mem[wrap(int'(a) + i)]) << (8 * i));
    return r;
  endfunction

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) break;
    end
    check({tag, " done seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic access(input bit wr, input logic [1:0] sz, input logic [AW-1:0] a,
                        input logic [31:0] wd, input string tag);
    int          n, cyc, w0;
    logic [31:0] rd_before;
    n = nbytes(sz);
    @(negedge clk);
    bus.start = 1'b1; bus.is_write = wr; bus.size = sz; bus.address = a; bus.wdata = wd;
    w0 = wr_count;
    rd_before = bus.rdata;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    wait_done(tag, cyc);
    check({tag, " latency"}, 32'(cyc), wr ? 32'(n) : 32'(n + 1));
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[wrap(int'(a) + i)] = wd[8*i +: 8];
      check({tag, " rdata held"}, bus.rdata, rd_before);
    end else begin
      check({tag, " rdata"}, bus.rdata, ref_read(a, sz));
    end
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    check({tag, " ram writes"}, 32'(wr_count - w0), wr ? 32'(n) : 32'd0);
    if (wr) begin
      for (int i = 0; i < n; i++)
        check({tag, " ram byte"}, 32'(ram[wrap(int'(a) + i)]), 32'(ref_mem[wrap(int'(a) + i)]));
    end
  endtask

  initial begin
    int cyc, w0;
    bus.start = 1'b0; bus.is_write = 1'b0; bus.size = 2'b00; bus.address = '0; bus.wdata = '0;
    reset = 1'b1;
    #2;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset rdata", bus.rdata, 32'd0);
    check("reset we", 32'(bus.mem_write_enable), 32'd0);
    check("reset addr", 32'(bus.mem_address), 32'd0);
    check("reset dout", 32'(bus.mem_data_out), 32'd0);
    @(negedge clk); reset = 1'b0;

    // 32-bit store/load
    access(1'b1, 2'b10, 12'h100, 32'h11223344, "wr32");
    check("wr32 byte0", 32'(ram[12'h100]), 32'h44);
    check("wr32 byte3", 32'(ram[12'h103]), 32'h11);
    access(1'b0, 2'b10, 12'h100, 32'h0, "rd32");
    check("rd32 value", bus.rdata, 32'h11223344);

    // Narrow reads zero-extend
    access(1'b1, 2'b00, 12'h200, 32'hFFFFFFA5, "wr8 a");
    access(1'b1, 2'b00, 12'h201, 32'h0000005A, "wr8 b");
    access(1'b0, 2'b00, 12'h200, 32'h0, "rd8");
    check("rd8 value", bus.rdata, 32'h000000A5);
    access(1'b0, 2'b01, 12'h200, 32'h0, "rd16");
    check("rd16 value", bus.rdata, 32'h00005AA5);

    // Address wrap-around
    access(1'b1, 2'b01, 12'hFFF, 32'h0000BEEF, "wrap wr");
    check("wrap hi", 32'(ram[12'h000]), 32'hBE);
    check("wrap lo", 32'(ram[12'hFFF]), 32'hEF);
    access(1'b0, 2'b01, 12'hFFF, 32'h0, "wrap rd");

    // Reserved size code acts as 4 bytes
    access(1'b1, 2'b11, 12'h040, 32'hCAFEF00D, "sz11 wr");
    access(1'b0, 2'b11, 12'h040, 32'h0, "sz11 rd");

    // Start held high: mid-access change ignored, next request taken in the done cycle
    @(negedge clk);
    bus.start = 1'b1; bus.is_write = 1'b0; bus.size = 2'b10; bus.address = 12'h100;
    w0 = wr_count;
    @(posedge clk); #1;
    bus.is_write = 1'b1; bus.size = 2'b10; bus.address = 12'h500; bus.wdata = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.is_write = 1'b0; bus.size = 2'b01; bus.address = 12'h200;
    wait_done("b2b first", cyc);
    check("b2b first latency", 32'(cyc + 2), 32'd5);
    check("b2b first rdata", bus.rdata, ref_read(12'h100, 2'b10));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b accept busy", 32'(bus.busy), 32'd1);
    check("b2b accept addr", 32'(bus.mem_address), 32'h200);
    wait_done("b2b second", cyc);
    check("b2b second latency", 32'(cyc), 32'd3);
    check("b2b second rdata", bus.rdata, ref_read(12'h200, 2'b01));
    check("b2b no writes", 32'(wr_count - w0), 32'd0);
    check("b2b ignored addr", 32'(ram[12'h500]), 32'(ref_mem[12'h500]));

    // Reset in the middle of a 4-byte store
    @(negedge clk);
    bus.start = 1'b1; bus.is_write = 1'b1; bus.size = 2'b10; bus.address = 12'h300;
    bus.wdata = 32'h89ABCDEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst mid we before", 32'(bus.mem_write_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("rst mid we", 32'(bus.mem_write_enable), 32'd0);
    check("rst mid busy", 32'(bus.busy), 32'd0);
    check("rst mid done", 32'(bus.done), 32'd0);
    @(negedge clk); reset = 1'b0;
    ref_mem[12'h300] = 8'hEF;
    ref_mem[12'h301] = 8'hCD;
    for (int i = 0; i < 4; i++)
      check("rst mid ram", 32'(ram[12'h300 + i]), 32'(ref_mem[12'h300 + i]));

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             AW'($urandom_range(0, MEM - 1)), $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
